// File: rtl/audio_sample_pacer.sv
// 48 kHz audio sample clock from a fractional phase accumulator, with a small stereo FIFO
// that presents one sample pair per period. Optional underrun counter: AUDIO_PACER_UNDERRUN_CNT_EN.
module audio_sample_pacer #(
  parameter int unsigned CLK_HZ  = 30000000,
  parameter int unsigned RATE_HZ = 48000,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             audio_clk,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic [15:0]      underrun_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] INC     = 32'(2 * RATE_HZ);
  localparam logic [31:0] LIMIT   = 32'(CLK_HZ);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [31:0]        acc;
  logic [31:0]        nxt;
  logic               half_tick;
  logic               fall;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;

  always_comb begin
    nxt       = acc + INC;
    half_tick = (nxt >= LIMIT);
    // Only a toggle from the accumulator counts as a falling edge; disable-forced lows never pop.
    fall      = enable && half_tick && audio_clk;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    in_ready  = rst_n && !full;
    push      = in_valid && in_ready;
    pop       = fall && !empty;
    head      = mem[rd_ptr[AW-1:0]];
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      audio_clk <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      if (enable) begin
        acc <= half_tick ? (nxt - LIMIT) : nxt;
        if (half_tick) begin
          audio_clk <= ~audio_clk;
        end
      end else begin
        acc       <= '0;
        audio_clk <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_left  <= head[2*WIDTH-1:WIDTH];
        out_right <= head[WIDTH-1:0];
      end
    end
  end

`ifdef AUDIO_PACER_UNDERRUN_CNT_EN
  logic [15:0] underruns;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underruns <= '0;
    end else if (fall && empty && (underruns != 16'hFFFF)) begin
      underruns <= underruns + 16'd1;
    end
  end

  assign underrun_count = underruns;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Self-checking bench for audio_sample_pacer: closed-form timing model plus a queue-based FIFO
// model compared every cycle, and directed scenarios with hand-computed expectations.
module tb_audio_sample_pacer;

  localparam int    CLK_HZ  = 30000000;
  localparam int    RATE_HZ = 48000;
  localparam int    W       = 24;
  localparam int    DEPTH   = 4;
  localparam longint INC_L  = 2 * RATE_HZ;
`ifdef AUDIO_PACER_UNDERRUN_CNT_EN
  localparam bit    CNT_ON  = 1'b1;
`else
  localparam bit    CNT_ON  = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_left;
  logic [W-1:0] in_right;
  logic         audio_clk;
  logic [W-1:0] out_left;
  logic [W-1:0] out_right;
  logic [15:0]  underrun_count;

  audio_sample_pacer #(
    .CLK_HZ (CLK_HZ),
    .RATE_HZ(RATE_HZ),
    .WIDTH  (W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_left       (in_left),
    .in_right      (in_right),
    .audio_clk     (audio_clk),
    .out_left      (out_left),
    .out_right     (out_right),
    .underrun_count(underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Model: half-ticks after n enabled cycles = floor(n*2*RATE/CLK); the clock level is its parity.
  longint         en_n;
  longint         t_prev;
  longint         t_now;
  bit             m_clk;
  logic [W-1:0]   m_l;
  logic [W-1:0]   m_r;
  int             m_under;
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] pair;
  bit             push_now;

  always @(posedge clk) begin
    if (!rst_n) begin
      en_n = 0; m_clk = 1'b0; m_l = '0; m_r = '0; m_under = 0;
      q.delete();
    end else begin
      push_now = in_valid && (q.size() < DEPTH);
      if (enable) begin
        en_n++;
        t_prev = ((en_n - 1) * INC_L) / CLK_HZ;
        t_now  = (en_n * INC_L) / CLK_HZ;
        m_clk  = t_now[0];
        if (t_now != t_prev && !t_now[0]) begin
          if (q.size() > 0) begin
            pair = q.pop_front();
            m_l  = pair[2*W-1:W];
            m_r  = pair[W-1:0];
          end else if (m_under < 65535) begin
            m_under++;
          end
        end
      end else begin
        en_n  = 0;
        m_clk = 1'b0;
      end
      if (push_now) q.push_back({in_left, in_right});
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (cmp_en) begin
      check("audio_clk", audio_clk, m_clk);
      check("out_left", out_left, m_l);
      check("out_right", out_right, m_r);
      check("in_ready", in_ready, rst_n && (q.size() < DEPTH));
      check("underrun_count", underrun_count, CNT_ON ? m_under : 0);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
    step(3);
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (audio_clk !== lvl && n < 2000);
  endtask

  task automatic run_count(input int k, output int rises);
    logic prev;
    rises = 0;
    prev  = audio_clk;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (!prev && audio_clk) rises++;
      prev = audio_clk;
    end
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    step(1);
    in_valid = 1'b0;
  endtask

  int data_k;
  int accepted;

  task automatic produce(input int cycles);
    bit took;
    for (int i = 0; i < cycles; i++) begin
      #3 took = in_valid && in_ready;
      @(negedge clk);
      if (took) begin
        accepted++;
        data_k++;
        in_left  = W'(32'h100 + data_k);
        in_right = W'(32'h200 + data_k);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n1;
  int n2;
  int rises;

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    step(2);
    cmp_en = 1'b1;

    // A: free-running, no input
    do_reset();
    check("reset_in_ready", in_ready, 0);
    check("reset_audio_clk", audio_clk, 0);
    rst_n = 1'b1; enable = 1'b1;
    wait_level(1'b1, n1);
    check("first_rise_cycle", n1, 313);
    wait_level(1'b0, n2);
    check("first_fall_cycle", n1 + n2, 625);
    run_count(6250 - 625, rises);
    check("rises_in_10_periods", rises + 1, 10);
    check("outs_idle", out_left, 0);
    check("underruns_10_periods", underrun_count, CNT_ON ? 10 : 0);
    $display("A free-run: rise@%0d fall@%0d rises=%0d underruns=%0d", n1, n1 + n2, rises + 1, underrun_count);

    // B: preload three pairs while disabled
    do_reset();
    rst_n = 1'b1;
    push_pair(24'd1, 24'd2);
    push_pair(24'd3, 24'd4);
    push_pair(24'd5, 24'd6);
    enable = 1'b1;
    step(624);
    check("preload_before_fall", out_left, 0);
    step(1);
    check("preload_l_625", out_left, 1);
    check("preload_r_625", out_right, 2);
    step(625);
    check("preload_l_1250", out_left, 3);
    check("preload_r_1250", out_right, 4);
    step(625);
    check("preload_l_1875", out_left, 5);
    check("preload_r_1875", out_right, 6);
    step(625);
    check("preload_hold_2500", out_right, 6);
    check("preload_underrun", underrun_count, CNT_ON ? 1 : 0);
    $display("B preload: out=(%0d,%0d) underruns=%0d", out_left, out_right, underrun_count);

    // C: continuous producer
    do_reset();
    data_k = 0; accepted = 0;
    in_left = W'(32'h100); in_right = W'(32'h200);
    rst_n = 1'b1; in_valid = 1'b1;
    produce(4);
    check("full_in_ready", in_ready, 0);
    check("full_accepted", accepted, 4);
    enable = 1'b1;
    produce(1900);
    in_valid = 1'b0;
    check("stream_accepted", accepted, 7);
    check("stream_out_l", out_left, 32'h102);
    check("stream_out_r", out_right, 32'h202);
    $display("C stream: accepted=%0d out=(%0h,%0h)", accepted, out_left, out_right);

    // D: push into empty FIFO exactly on the falling half-tick
    do_reset();
    rst_n = 1'b1; enable = 1'b1;
    step(624);
    push_pair(24'd7, 24'd8);
    check("coincide_underrun_l", out_left, 0);
    check("coincide_clk", audio_clk, 0);
    step(624);
    check("coincide_before_next", out_left, 0);
    step(1);
    check("coincide_l_1250", out_left, 7);
    check("coincide_r_1250", out_right, 8);
    $display("D coincident push: out=(%0d,%0d)", out_left, out_right);

    // E: reset mid-period with two pairs buffered
    do_reset();
    rst_n = 1'b1;
    push_pair(24'd20, 24'd21);
    push_pair(24'd22, 24'd23);
    push_pair(24'd24, 24'd25);
    enable = 1'b1;
    step(700);
    check("pre_reset_out", out_left, 20);
    rst_n = 1'b0;
    step(1);
    check("midreset_out_l", out_left, 0);
    check("midreset_out_r", out_right, 0);
    check("midreset_in_ready", in_ready, 0);
    check("midreset_clk", audio_clk, 0);
    rst_n = 1'b1;
    wait_level(1'b1, n1);
    check("post_reset_rise", n1, 313);
    step(312);
    check("post_reset_fifo_empty", out_left, 0);
    $display("E mid reset: rise@%0d out=(%0d,%0d)", n1, out_left, out_right);

    // F: disable while audio_clk is high
    do_reset();
    rst_n = 1'b1;
    push_pair(24'd11, 24'd12);
    push_pair(24'd13, 24'd14);
    enable = 1'b1;
    step(950);
    check("pre_disable_clk", audio_clk, 1);
    enable = 1'b0;
    step(1);
    check("disable_clk_low", audio_clk, 0);
    check("disable_no_pop", out_left, 11);
    step(10);
    enable = 1'b1;
    wait_level(1'b1, n1);
    check("reenable_rise", n1, 313);
    step(312);
    check("reenable_pop_l", out_left, 13);
    check("reenable_pop_r", out_right, 14);
    $display("F disable: rise@%0d out=(%0d,%0d)", n1, out_left, out_right);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_pacer.md
# audio_sample_pacer

Generates the 48 kHz audio sample clock for the HDMI transmitter from the 30 MHz system clock. It uses an exact fractional phase accumulator, so there is no integer-divide rate error. It buffers stereo samples from the synthesizer in a small FIFO and presents one sample pair per audio period, held stable across the rising edge of the generated clock. It sits between the synth audio mixer (valid/ready producer) and the HDMI transmitter's audio clock and sample inputs, and replaces the ad-hoc clock divider in the display top level.

## Interface
Parameters:
- `CLK_HZ`, 30000000, input clock frequency in Hz.
- `RATE_HZ`, 48000, output sample rate in Hz. Requires 2*RATE_HZ < CLK_HZ.
- `WIDTH`, 24, bits per channel sample.
- `DEPTH`, 4, FIFO depth in sample pairs. Power of two, ≥2.

Ports:
- `clk` in 1: system clock (clk30 domain).
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `enable` in 1: level. Low freezes clock generation.
- `in_valid` in 1: producer has a sample pair.
- `in_ready` out 1: FIFO can accept a sample pair.
- `in_left` in WIDTH: left sample.
- `in_right` in WIDTH: right sample.
- `audio_clk` out 1: registered square wave at RATE_HZ, intended to drive a BUFG.
- `out_left` out WIDTH: current left sample.
- `out_right` out WIDTH: current right sample.
- `underrun_count` out 16: saturating underrun count; see Configuration.

## Operation
- Accumulator `acc`: 32 bits, unsigned. Each enabled cycle, compute `nxt = acc + 2*RATE_HZ`.
  - If `nxt >= CLK_HZ`: `acc <= nxt - CLK_HZ`, and a half-tick occurs.
  - Otherwise: `acc <= nxt`.
  - `acc` never reaches CLK_HZ. No other wrap exists.
- Half-tick: `audio_clk` toggles.
- Falling half-tick (`audio_clk` 1→0): one pop is attempted in the same cycle.
  - FIFO non-empty: the head pair is registered into `out_left`/`out_right`.
  - FIFO empty: this is an underrun. The outputs hold the previous pair.
- FIFO: DEPTH entries, 2*WIDTH bits each, with read/write pointers one bit wider than log2(DEPTH).
  - `in_ready = rst_n && !full`. This is combinational from registered state.
  - Push happens when `in_valid && in_ready`.
- Simultaneous push and pop, FIFO non-empty: both occur and occupancy is unchanged.
- Simultaneous push and pop, FIFO empty: there is no bypass. The pop underruns, and the pushed pair is used at the next falling half-tick.
- Full: `in_ready` is 0, so no push can occur. A pop in that cycle frees a slot, and `in_ready` is 1 on the next cycle.
- `enable` low:
  - `acc` is held at 0 and `audio_clk` is driven to 0 (registered).
  - No pops occur. Pushes continue until the FIFO is full.
  - A 1→0 on `audio_clk` caused by disable does not pop.
- Reset (`rst_n` sampled low, at any time, including mid-period):
  - `acc=0`, `audio_clk=0`, `out_left=0`, `out_right=0`, FIFO empty, `underrun_count=0`.
  - `in_ready=0` while `rst_n` is low. Pushes are ignored during reset.

## Timing
- With defaults, the increment is 96000 per cycle.
- First half-tick: on the 313th enabled cycle after `acc=0`.
- After that, half periods alternate 312/313 cycles, starting with 312.
- Every `audio_clk` period is exactly 625 cycles: 48000.000 Hz.
- Output latency: `out_*` change in the same registered update in which `audio_clk` falls. They are then stable for 312 or 313 cycles before the next rising edge.
- Push-to-visible latency: a pair pushed into an empty FIFO appears at the first falling half-tick strictly after the push cycle.
- `in_ready` deasserts in the cycle after the push that fills the FIFO.
- All outputs are registered except `in_ready`.

## Configuration
- `AUDIO_PACER_UNDERRUN_CNT_EN` defined:
  - A 16-bit counter increments on each underrun pop and saturates at 0xFFFF.
  - It clears on reset and drives `underrun_count`.
- Not defined:
  - The counter logic is omitted and `underrun_count` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Defaults, `enable=1` from reset, no input: first `audio_clk` rise at cycle 313 and first fall at cycle 625. Over 30,000,000 cycles, exactly 48000 rising edges. `out_*` stay 0. `underrun_count` reaches 48000 with the macro and stays 0 without it.
- Preload pairs (1,2), (3,4), (5,6) with `enable=0`, then enable: `out_*` = (1,2) at cycle 625, (3,4) at 1250, (5,6) at 1875, then held at (5,6) with underruns counted.
- Continuous `in_valid`: the FIFO fills to 4 and `in_ready` drops. After each falling half-tick, exactly one push is accepted. No pair is lost or duplicated (scoreboard).
- Push into an empty FIFO in the exact cycle of a falling half-tick: that pop underruns, and the pushed pair appears at the next fall, 625 cycles later.
- Assert `rst_n=0` mid-period with the FIFO holding 2 pairs: the next cycle has all outputs 0 and `in_ready=0`. After release, the FIFO is empty and the first rise is at cycle 313.
- Deassert `enable` while `audio_clk=1`: `audio_clk` goes 0 with `out_*` unchanged and no pop. Re-enable: the first rise is 313 cycles later.
